// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX boundary: datapath widths and the layout of
// the packed control bundle used by the decoder, this register and EX.
package id_ex_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 11;

  // Control bundle bit positions, MSB first:
  // reg_write, mem_read, mem_write, result_src[1:0], alu_src, alu_ctrl[2:0], branch, jump
  localparam int CTRL_REG_WRITE     = 10;
  localparam int CTRL_MEM_READ      = 9;
  localparam int CTRL_MEM_WRITE     = 8;
  localparam int CTRL_RESULT_SRC_HI = 7;
  localparam int CTRL_RESULT_SRC_LO = 6;
  localparam int CTRL_ALU_SRC       = 5;
  localparam int CTRL_ALU_CTRL_HI   = 4;
  localparam int CTRL_ALU_CTRL_LO   = 2;
  localparam int CTRL_BRANCH        = 1;
  localparam int CTRL_JUMP          = 0;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] result_src;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // A non-valid slot must never carry side-effecting control into EX.
  function automatic logic [CTRL_W-1:0] ctrl_gate(input logic valid,
                                                  input logic [CTRL_W-1:0] ctrl);
    return valid ? ctrl : CTRL_NOP;
  endfunction

endpackage

// File: rtl/id_ex_stage_wb_bypass_sel.sv
// Next-value select for one ID/EX operand: WB data wins on a matching non-x0
// write, otherwise the register file value (capture) or the held value (stall).
module wb_bypass_sel #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rf_data,
  input  logic [XLEN-1:0]   held_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              sel_hold,
  output logic [XLEN-1:0]   next_data
);

  logic w_hit;

  assign w_hit = wb_we && (wb_rd != '0) && (wb_rd == rs);

  always_comb begin
    next_data = sel_hold ? held_data : rf_data;
    if (w_hit) next_data = wb_wd;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass at capture and WB snooping of held
// operands while stalled. Priority per edge: rst > flush > stall > load.
module id_ex_stage #(
  parameter int XLEN   = id_ex_stage_pkg::XLEN,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW,
  parameter int CTRL_W = id_ex_stage_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_pc_plus4,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [XLEN-1:0]   rf_rd1,
  input  logic [XLEN-1:0]   rf_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_pc_plus4,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl
);

  import id_ex_stage_pkg::*;

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_pc_plus4;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [XLEN-1:0]   r_rd1;
  logic [XLEN-1:0]   r_rd2;
  logic [XLEN-1:0]   r_imm;
  logic [CTRL_W-1:0] r_ctrl;

  logic [REG_AW-1:0] w_rs1_sel;
  logic [REG_AW-1:0] w_rs2_sel;
  logic              w_bypass_we;
  logic [XLEN-1:0]   w_rd1_next;
  logic [XLEN-1:0]   w_rd2_next;

  // While stalled the comparison is against the held source regs, and a
  // bubble (ex_valid=0) is left alone so it never picks up WB traffic.
  assign w_rs1_sel   = stall ? r_rs1 : id_rs1;
  assign w_rs2_sel   = stall ? r_rs2 : id_rs2;
  assign w_bypass_we = wb_we & (~stall | r_valid);

  wb_bypass_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_sel_rd1 (
    .rs        (w_rs1_sel),
    .rf_data   (rf_rd1),
    .held_data (r_rd1),
    .wb_we     (w_bypass_we),
    .wb_rd     (wb_rd),
    .wb_wd     (wb_wd),
    .sel_hold  (stall),
    .next_data (w_rd1_next)
  );

  wb_bypass_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_sel_rd2 (
    .rs        (w_rs2_sel),
    .rf_data   (rf_rd2),
    .held_data (r_rd2),
    .wb_we     (w_bypass_we),
    .wb_rd     (wb_rd),
    .wb_wd     (wb_wd),
    .sel_hold  (stall),
    .next_data (w_rd2_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_ctrl     <= CTRL_NOP;
    end else if (flush) begin
      // Data fields deliberately hold; only the qualifiers are killed.
      r_valid <= 1'b0;
      r_ctrl  <= CTRL_NOP;
    end else if (stall) begin
      r_rd1 <= w_rd1_next;
      r_rd2 <= w_rd2_next;
    end else begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_pc_plus4 <= id_pc_plus4;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_rd1      <= w_rd1_next;
      r_rd2      <= w_rd2_next;
      r_imm      <= id_imm;
      r_ctrl     <= ctrl_gate(id_valid, id_ctrl);
    end
  end

  assign ex_valid    = r_valid;
  assign ex_pc       = r_pc;
  assign ex_pc_plus4 = r_pc_plus4;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_rd1      = r_rd1;
  assign ex_rd2      = r_rd2;
  assign ex_imm      = r_imm;
  assign ex_ctrl     = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a register-file-level reference model
// predicts each EX slot; a monitor compares it at the following negedge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_pc_plus4 = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [31:0] rf_rd1, rf_rd2;
  logic [10:0] id_ctrl = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_wd = '0;
  logic        stall = 1'b0, flush = 1'b0;

  logic        ex_valid;
  logic [31:0] ex_pc, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [10:0] ex_ctrl;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc_plus4(ex_pc_plus4),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rd1(ex_rd1),
    .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  // Architectural register file: read combinationally, written after posedge.
  logic [31:0] rf_m [32];
  assign rf_rd1 = rf_m[id_rs1];
  assign rf_rd2 = rf_m[id_rs2];

  typedef struct packed {
    logic        valid;
    logic        known;
    logic [31:0] pc, pc4, imm, rd1, rd2;
    logic [4:0]  rs1, rs2, rd;
    logic [10:0] ctrl;
  } exp_t;

  exp_t m;
  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Value register r holds once this edge's WB write has landed.
  function automatic logic [31:0] arch_after(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_wd;
    return rf_m[r];
  endfunction

  // An instruction sitting in EX must always see the current architectural
  // value of its sources; a killed or empty slot keeps whatever it had.
  task automatic model_edge();
    if (flush) begin
      m.valid = 1'b0;
      m.ctrl  = '0;
    end else if (stall) begin
      if (m.valid) begin
        m.rd1 = arch_after(m.rs1);
        m.rd2 = arch_after(m.rs2);
      end
    end else begin
      m.valid = id_valid;
      m.known = id_valid;
      m.pc    = id_pc;
      m.pc4   = id_pc_plus4;
      m.rs1   = id_rs1;
      m.rs2   = id_rs2;
      m.rd    = id_rd;
      m.imm   = id_imm;
      m.ctrl  = id_valid ? id_ctrl : 11'd0;
      m.rd1   = arch_after(id_rs1);
      m.rd2   = arch_after(id_rs2);
    end
  endtask

  task automatic step();
    model_edge();
    q.push_back(m);
    @(posedge clk);
    #1;
    if (wb_we && wb_rd != 5'd0) rf_m[wb_rd] = wb_wd;
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                       input logic [10:0] ctrl, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wwd, input logic st, input logic fl);
    id_valid = v; id_pc = pc; id_pc_plus4 = pc + 32'd4; id_rs1 = rs1; id_rs2 = rs2;
    id_rd = rd; id_imm = imm; id_ctrl = ctrl; wb_we = we; wb_rd = wrd; wb_wd = wwd;
    stall = st; flush = fl;
    step();
  endtask

  // Called just after a negedge: async pulse well before the next posedge.
  task automatic do_reset();
    id_valid = 1'b1; id_pc = $urandom | 32'h1; id_pc_plus4 = id_pc + 32'd4;
    id_rs1 = 5'd3; id_rs2 = 5'd4; id_rd = 5'd6; id_imm = $urandom | 32'h1;
    id_ctrl = 11'h7FF; wb_we = 1'b1; wb_rd = 5'd3; wb_wd = $urandom | 32'h1;
    stall = 1'b1; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst ex_pc", ex_pc, 32'd0);
    chk("rst ex_pc_plus4", ex_pc_plus4, 32'd0);
    chk("rst ex_rs1", {27'd0, ex_rs1}, 32'd0);
    chk("rst ex_rs2", {27'd0, ex_rs2}, 32'd0);
    chk("rst ex_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst ex_rd1", ex_rd1, 32'd0);
    chk("rst ex_rd2", ex_rd2, 32'd0);
    chk("rst ex_imm", ex_imm, 32'd0);
    chk("rst ex_ctrl", {21'd0, ex_ctrl}, 32'd0);
    #1 rst = 1'b0;
    q.delete();
    m = '0;
    m.known = 1'b1;
  endtask

  // Monitor: every negedge the DUT presents the slot captured at the last posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
        chk("ex_ctrl", {21'd0, ex_ctrl}, {21'd0, e.ctrl});
        if (e.known) begin
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_pc_plus4", ex_pc_plus4, e.pc4);
          chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, e.rs1});
          chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, e.rs2});
          chk("ex_rd", {27'd0, ex_rd}, {27'd0, e.rd});
          chk("ex_imm", ex_imm, e.imm);
          chk("ex_rd1", ex_rd1, e.rd1);
          chk("ex_rd2", ex_rd2, e.rd2);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = (i == 0) ? 32'd0 : $urandom;
    m = '0;
    @(negedge clk);
    do_reset();

    // First capture after reset release
    drive(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h10, 11'h123, 0, 5'd0, 32'd0, 0, 0);

    // Capture bypass, then the x0 case that must not bypass
    rf_m[5] = 32'h11;
    drive(1, 32'h104, 5'd5, 5'd3, 5'd9, 32'h20, 11'h4A5, 1, 5'd5, 32'hDEADBEEF, 0, 0);
    drive(1, 32'h108, 5'd0, 5'd3, 5'd9, 32'h24, 11'h4A5, 1, 5'd0, 32'hDEADBEEF, 0, 0);

    // Stall snoop on operand 2, WB write lands in the second stall cycle
    rf_m[7] = 32'h1;
    drive(1, 32'h200, 5'd2, 5'd7, 5'd8, 32'h30, 11'h3C1, 0, 5'd0, 32'd0, 0, 0);
    drive(1, $urandom, 5'd9, 5'd10, 5'd11, $urandom, 11'h7FF, 0, 5'd0, 32'd0, 1, 0);
    drive(1, $urandom, 5'd9, 5'd10, 5'd11, $urandom, 11'h7FF, 1, 5'd7, 32'h55, 1, 0);
    drive(1, $urandom, 5'd9, 5'd10, 5'd11, $urandom, 11'h7FF, 0, 5'd0, 32'd0, 1, 0);

    // Snoop updating both operands when they name the same register
    drive(1, 32'h210, 5'd12, 5'd12, 5'd1, 32'h4, 11'h101, 0, 5'd0, 32'd0, 0, 0);
    drive(0, $urandom, 5'd1, 5'd1, 5'd1, $urandom, 11'h000, 1, 5'd12, 32'hCAFE0001, 1, 0);

    // Flush wins over stall
    drive(1, 32'h300, 5'd1, 5'd2, 5'd3, 32'h40, 11'h7FF, 0, 5'd0, 32'd0, 0, 0);
    drive(1, 32'h304, 5'd4, 5'd5, 5'd6, 32'h44, 11'h7FF, 1, 5'd1, 32'h77, 1, 1);

    // Invalid capture
    drive(0, 32'h400, 5'd1, 5'd2, 5'd3, 32'h50, 11'h7FF, 0, 5'd0, 32'd0, 0, 0);

    // Back-to-back loads, WB busy on an unrelated register
    for (int i = 0; i < 4; i++)
      drive(1, 32'(i * 4), 5'd1, 5'd2, 5'd4, 32'(i), 11'h081, 1, 5'd3, $urandom, 0, 0);

    // Randomised traffic on a small register window so hits are frequent
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom,
            11'($urandom), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
            $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    #1;
    chk("scoreboard drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
